// File: rtl/core_run_ctrl_pkg.sv
// core_run_pkg: state encodings and defaults shared by the run controller.
package core_run_pkg;
    localparam int RUN_ST_BIT = 3;
    localparam logic [RUN_ST_BIT-1:0] RUN_ST_IDLE   = 3'd0;
    localparam logic [RUN_ST_BIT-1:0] RUN_ST_RUN    = 3'd1;
    localparam logic [RUN_ST_BIT-1:0] RUN_ST_STEP   = 3'd2;
    localparam logic [RUN_ST_BIT-1:0] RUN_ST_PAUSED = 3'd3;
    localparam logic [RUN_ST_BIT-1:0] RUN_ST_HALTED = 3'd4;
    localparam int CNT_W_DEF = 32;
endpackage

// File: rtl/core_run_ctrl_sat_counter.sv
// sat_counter: saturating up-counter, clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && q != '1)
            q <= q + 1'b1;
    end
endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run/step/breakpoint sequencer driving the CPU enable, plus perf counters.
module core_run_ctrl
    import core_run_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_run,
    input  logic                  cmd_step,
    input  logic                  cmd_pause,
    input  logic                  cnt_clr,
    input  logic                  bp_en,
    input  logic [31:0]           bp_addr,
    input  logic [31:0]           pc_dbg,
    input  logic                  halted,
    input  logic                  jumped,
    input  logic                  branched,
    input  logic                  bubble,
    output logic                  core_en,
    output logic [RUN_ST_BIT-1:0] state,
    output logic                  bp_hit,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      branch_cnt,
    output logic [CNT_W-1:0]      jump_cnt
);
    logic [RUN_ST_BIT-1:0] r_state;
    logic [RUN_ST_BIT-1:0] w_state_nxt;
    logic                  r_bp_skip;
    logic                  r_bp_hit;
    logic                  w_bp_stop;
    logic                  w_leave_paused;

    assign w_bp_stop      = (r_state == RUN_ST_RUN) && bp_en && (pc_dbg == bp_addr) && !r_bp_skip;
    assign core_en        = ((r_state == RUN_ST_RUN) && !w_bp_stop) || (r_state == RUN_ST_STEP);
    assign w_leave_paused = (r_state == RUN_ST_PAUSED) && (w_state_nxt != RUN_ST_PAUSED);
    assign state          = r_state;
    assign bp_hit         = r_bp_hit;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN_ST_IDLE, RUN_ST_PAUSED:
                w_state_nxt = cmd_pause ? r_state : cmd_step ? RUN_ST_STEP : cmd_run ? RUN_ST_RUN : r_state;
            RUN_ST_RUN:
                w_state_nxt = (halted && core_en) ? RUN_ST_HALTED :
                              (w_bp_stop || cmd_pause) ? RUN_ST_PAUSED : RUN_ST_RUN;
            RUN_ST_STEP:
                w_state_nxt = halted ? RUN_ST_HALTED : RUN_ST_PAUSED;
            RUN_ST_HALTED:
                w_state_nxt = RUN_ST_HALTED;
            default:
                w_state_nxt = RUN_ST_IDLE;
        endcase
    end

    // Skip stays armed until the core has actually moved off the breakpoint address.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state   <= RUN_ST_IDLE;
            r_bp_skip <= 1'b0;
            r_bp_hit  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bp_skip <= w_leave_paused ? 1'b1 : (core_en && pc_dbg != bp_addr) ? 1'b0 : r_bp_skip;
            r_bp_hit  <= w_bp_stop ? 1'b1 : w_leave_paused ? 1'b0 : r_bp_hit;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(core_en), .q(cycle_cnt)
    );
    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(core_en && bubble), .q(bubble_cnt)
    );
    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(core_en && branched), .q(branch_cnt)
    );
    sat_counter #(.W(CNT_W)) u_jump_cnt (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(core_en && jumped), .q(jump_cnt)
    );
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: directed plan plus randomized traffic against a behavioural run-control model.
module tb_core_run_ctrl;
    localparam int CW     = 8;
    localparam int CMAX   = 255;
    localparam int S_IDLE = 0, S_RUN = 1, S_STEP = 2, S_PAUSED = 3, S_HALT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_run = 1'b0, cmd_step = 1'b0, cmd_pause = 1'b0, cnt_clr = 1'b0;
    logic          bp_en = 1'b0;
    logic [31:0]   bp_addr = '0, pc_dbg = '0, pc_wrap = 32'hffff_ffff;
    logic          halted = 1'b0, jumped = 1'b0, branched = 1'b0, bubble = 1'b0;
    logic          core_en, bp_hit;
    logic [2:0]    state;
    logic [CW-1:0] cycle_cnt, bubble_cnt, branch_cnt, jump_cnt;

    int n_pass = 0, n_total = 0;
    int m_state = S_IDLE;
    bit m_skip = 1'b0, m_hit = 1'b0;
    int m_cnt[4] = '{0, 0, 0, 0};
    int c0, b0;

    core_run_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_pause(cmd_pause),
        .cnt_clr(cnt_clr), .bp_en(bp_en), .bp_addr(bp_addr), .pc_dbg(pc_dbg), .halted(halted),
        .jumped(jumped), .branched(branched), .bubble(bubble), .core_en(core_en), .state(state),
        .bp_hit(bp_hit), .cycle_cnt(cycle_cnt), .bubble_cnt(bubble_cnt), .branch_cnt(branch_cnt),
        .jump_cnt(jump_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit m_en();
        return (m_state == S_RUN && !(bp_en && pc_dbg == bp_addr && !m_skip)) || m_state == S_STEP;
    endfunction

    // One clock: compare DUT to the model mid-cycle, advance the model, then let the fake core move its PC.
    task automatic cyc();
        bit en, stop;
        bit q[4];
        int nxt;
        @(negedge clk);
        en = m_en();
        chk("core_en", 32'(core_en), 32'(en));
        chk("state", 32'(state), m_state);
        chk("bp_hit", 32'(bp_hit), 32'(m_hit));
        chk("cycle_cnt", 32'(cycle_cnt), m_cnt[0]);
        chk("bubble_cnt", 32'(bubble_cnt), m_cnt[1]);
        chk("branch_cnt", 32'(branch_cnt), m_cnt[2]);
        chk("jump_cnt", 32'(jump_cnt), m_cnt[3]);
        stop = m_state == S_RUN && bp_en && pc_dbg == bp_addr && !m_skip;
        q = '{1'b1, bubble, branched, jumped};
        for (int k = 0; k < 4; k++)
            m_cnt[k] = cnt_clr ? 0 : (en && q[k]) ? ((m_cnt[k] + 1 > CMAX) ? CMAX : m_cnt[k] + 1) : m_cnt[k];
        nxt = m_state;
        if (en && pc_dbg != bp_addr) m_skip = 1'b0;
        case (m_state)
            S_IDLE, S_PAUSED:
                if (!cmd_pause && (cmd_step || cmd_run)) begin
                    nxt = cmd_step ? S_STEP : S_RUN;
                    if (m_state == S_PAUSED) begin
                        m_skip = 1'b1;
                        m_hit  = 1'b0;
                    end
                end
            S_RUN:
                if (halted && en) nxt = S_HALT;
                else if (stop) begin
                    nxt   = S_PAUSED;
                    m_hit = 1'b1;
                end else if (cmd_pause) nxt = S_PAUSED;
            S_STEP: nxt = halted ? S_HALT : S_PAUSED;
            default: ;
        endcase
        m_state = nxt;
        @(posedge clk);
        #1;
        if (en && !bubble) pc_dbg = (pc_dbg + 32'd4) & pc_wrap;
        cmd_run = 1'b0; cmd_step = 1'b0; cmd_pause = 1'b0; cnt_clr = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        #1;
        chk("rst core_en", 32'(core_en), 0);
        chk("rst state", 32'(state), S_IDLE);
        chk("rst bp_hit", 32'(bp_hit), 0);
        chk("rst cycle_cnt", 32'(cycle_cnt), 0);
        m_state = S_IDLE; m_skip = 1'b0; m_hit = 1'b0; m_cnt = '{0, 0, 0, 0};
        pc_dbg = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
    endtask

    initial begin
        #2;
        // plan 1: run and count
        do_reset();
        cmd_run = 1'b1; cyc();
        chk("t1 state", 32'(state), S_RUN);
        chk("t1 core_en", 32'(core_en), 1);
        repeat (10) cyc();
        chk("t1 cycle_cnt", 32'(cycle_cnt), 10);
        chk("t1 bubble_cnt", 32'(bubble_cnt), 0);
        // plan 2: breakpoint stop and resume past it
        do_reset();
        bp_en = 1'b1; bp_addr = 32'h10;
        cmd_run = 1'b1; cyc();
        repeat (4) cyc();
        chk("t2 en at bp", 32'(core_en), 0);
        cyc();
        chk("t2 paused", 32'(state), S_PAUSED);
        chk("t2 bp_hit", 32'(bp_hit), 1);
        cmd_run = 1'b1; cyc();
        chk("t2 resume en", 32'(core_en), 1);
        chk("t2 resume state", 32'(state), S_RUN);
        cyc();
        chk("t2 past bp en", 32'(core_en), 1);
        chk("t2 bp_hit clr", 32'(bp_hit), 0);
        // plan 3: single step with a bubble
        cmd_pause = 1'b1; cyc();
        chk("t3 paused", 32'(state), S_PAUSED);
        c0 = m_cnt[0]; b0 = m_cnt[1];
        cmd_step = 1'b1; cyc();
        bubble = 1'b1;
        chk("t3 step state", 32'(state), S_STEP);
        chk("t3 step en", 32'(core_en), 1);
        cyc();
        bubble = 1'b0;
        chk("t3 after step", 32'(state), S_PAUSED);
        chk("t3 after en", 32'(core_en), 0);
        chk("t3 cycle_cnt", 32'(cycle_cnt), c0 + 1);
        chk("t3 bubble_cnt", 32'(bubble_cnt), b0 + 1);
        // plan 5: command priority
        cmd_run = 1'b1; cyc();
        cmd_pause = 1'b1; cmd_run = 1'b1; cyc();
        chk("t5 pause>run", 32'(state), S_PAUSED);
        cmd_step = 1'b1; cmd_run = 1'b1; cyc();
        chk("t5 step>run", 32'(state), S_STEP);
        cyc();
        chk("t5 step done", 32'(state), S_PAUSED);
        // plan 4: halt is sticky
        cmd_run = 1'b1; cyc();
        halted = 1'b1; cyc();
        halted = 1'b0;
        chk("t4 halted", 32'(state), S_HALT);
        chk("t4 halted en", 32'(core_en), 0);
        cmd_run = 1'b1; cyc();
        cmd_step = 1'b1; cyc();
        cmd_pause = 1'b1; cyc();
        chk("t4 sticky", 32'(state), S_HALT);
        do_reset();
        chk("t4 reset exit", 32'(state), S_IDLE);
        // plan 6: saturation and clear priority
        bp_en = 1'b0;
        cmd_run = 1'b1; cyc();
        repeat (300) begin
            bubble = 1'($urandom_range(0, 1)); branched = 1'($urandom_range(0, 1)); jumped = 1'($urandom_range(0, 1));
            cyc();
        end
        bubble = 1'b0; branched = 1'b0; jumped = 1'b0;
        chk("t6 saturated", 32'(cycle_cnt), CMAX);
        cnt_clr = 1'b1;
        chk("t6 clr en", 32'(core_en), 1);
        cyc();
        chk("t6 cleared", 32'(cycle_cnt), 0);
        // randomized traffic
        pc_wrap = 32'h3f;
        repeat (1500) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            cmd_run   = ($urandom_range(0, 5) == 0);
            cmd_step  = ($urandom_range(0, 6) == 0);
            cmd_pause = ($urandom_range(0, 7) == 0);
            cnt_clr   = ($urandom_range(0, 49) == 0);
            halted    = ($urandom_range(0, 59) == 0);
            bp_en     = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) bp_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            bubble = ($urandom_range(0, 3) == 0); branched = 1'($urandom_range(0, 1)); jumped = 1'($urandom_range(0, 1));
            cyc();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Run/step/breakpoint sequencer for the 5-stage pipelined CPU top. It generates the core's global enable (`en`) from host commands, a PC breakpoint and the core's `halted` flag. It also keeps saturating performance counters of enabled cycles, bubbles, taken branches and jumps. It sits between the board/debug host logic and the CPU top, and the CPU's `en` input is driven only by `core_en`.

Parameters:
CNT_W, 32, width of each performance counter (legal range 8..32)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-high reset (asserted = 1), despite the name
cmd_run  in  1  one-cycle pulse: free-run the core
cmd_step  in  1  one-cycle pulse: advance the core by exactly one enabled cycle
cmd_pause  in  1  one-cycle pulse: stop the core
cnt_clr  in  1  synchronous clear of all counters
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint byte address, compared against pc_dbg
pc_dbg  in  32  core PC (byte address)
halted  in  1  core halt flag
jumped  in  1  core jump status, qualified by core_en
branched  in  1  core branch-taken status, qualified by core_en
bubble  in  1  core stall status, qualified by core_en
core_en  out  1  enable to the CPU top (combinational from state and bp match)
state  out  3  current FSM state
bp_hit  out  1  sticky flag: last stop was caused by the breakpoint
cycle_cnt  out  CNT_W  count of core_en cycles
bubble_cnt  out  CNT_W  count of cycles with core_en && bubble
branch_cnt  out  CNT_W  count of cycles with core_en && branched
jump_cnt  out  CNT_W  count of cycles with core_en && jumped

Behaviour:
- Reset (rst_n=1, async):
  - state=IDLE, bp_skip=0, bp_hit=0, all counters=0.
  - core_en=0 throughout reset.
- States:
  - IDLE=0: core_en=0.
  - RUN=1: core_en = !bp_stop.
  - STEP=2: core_en=1 for exactly this one cycle.
  - PAUSED=3: core_en=0.
  - HALTED=4: core_en=0.
  - Codes 5..7 are unreachable; if ever reached, they behave as IDLE on the next edge.
- Breakpoint stop: bp_stop = bp_en && (pc_dbg == bp_addr) && !bp_skip, evaluated only in RUN.
- Command priority when several commands pulse in the same cycle: cmd_pause > cmd_step > cmd_run.
- Transitions (registered, take effect next cycle):
  - IDLE/PAUSED: cmd_run -> RUN; cmd_step -> STEP; cmd_pause -> stay.
  - RUN: halted && core_en -> HALTED (highest priority); else bp_stop -> PAUSED and set bp_hit; else cmd_pause -> PAUSED; else stay.
  - STEP: halted -> HALTED; else -> PAUSED regardless of any command.
  - HALTED: sticky; only rst_n exits. Commands are ignored.
- Latency: a cmd_run pulse at edge t gives core_en=1 in cycle t+1. cmd_pause in RUN at cycle t still has core_en=1 in cycle t; core_en=0 from t+1.
- Resume past a breakpoint: bp_skip is set on any transition out of PAUSED (into RUN or STEP).
  - bp_skip clears after the first cycle in which core_en=1 and pc_dbg != bp_addr.
  - A bubble that holds the PC at bp_addr therefore does not re-trigger the breakpoint.
- bp_hit clears on any cmd_run or cmd_step accepted from PAUSED.
- Step granularity is one enabled clock, not one retired instruction. A step during a bubble leaves pc_dbg unchanged.
- Counters:
  - Each counter increments by 1 when its qualifier is 1 in a cycle.
  - Each saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr has priority over increment in the same cycle.
  - Counters are not cleared by state changes.
- No combinational path from cmd_* to core_en; all commands act through the state register.

Decomposition:
- Package core_run_pkg holds:
  - the state encodings (RUN_ST_IDLE..RUN_ST_HALTED) and RUN_ST_BIT=3;
  - the default CNT_W.
- Sub-module sat_counter #(W): inputs clk, rst_n, clr, inc; output q.
  - Saturating, clr has priority over inc.
  - Instantiated four times.
- The FSM and breakpoint logic stay in core_run_ctrl.

Test Plan:
1. Reset then cmd_run: state=1 and core_en=1 from the next cycle. After 10 cycles with bubble=0, cycle_cnt=10 and bubble_cnt=0.
2. bp_en=1, bp_addr=0x00000010, pc_dbg steps 0x0,0x4,...: core_en=0 in the cycle pc_dbg=0x10, then state=3 and bp_hit=1. A following cmd_run gives core_en=1 in the very next cycle with pc_dbg still 0x10, and the run continues to 0x14.
3. From PAUSED, cmd_step: exactly one cycle with core_en=1 followed by state=3; cycle_cnt increases by 1. With bubble=1 in that cycle, bubble_cnt increases by 1 as well.
4. In RUN, halted=1: state=4 next cycle and core_en=0. Subsequent cmd_run, cmd_step and cmd_pause leave state=4; only rst_n=1 returns state=0.
5. cmd_pause and cmd_run pulsed in the same cycle while in RUN: state=3. cmd_step and cmd_run pulsed together from PAUSED: state=2, then 3.
6. CNT_W=8, run 300 enabled cycles: cycle_cnt=255 (saturated). Asserting cnt_clr and core_en in the same cycle gives 0 next cycle.
